// File: rtl/gcd_arbiter_if.sv
// Request/response bundle between the GCD arbiter and its client blocks.
// slave  : arbiter side (accepts requests, drives responses)
// master : client side (drives requests, accepts responses)
interface gcd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic [ID_WIDTH-1:0]           rsp_id_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic                          rsp_err_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine between NUM_REQ requesters.
// One operation in flight; zero operands bypass the engine (gcd(0,x)=x).
// Optional engine watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no operation; grant first valid requester from rr pointer
// S_ISSUE | operands latched, one-cycle start pulse to the engine
// S_WAIT  | waiting for eng_done_i (or watchdog expiry)
// S_RESP  | response presented, held until rsp_ready_i
module gcd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  gcd_arbiter_if.slave          bus,
  output logic                  eng_start_o,
  output logic [DATA_WIDTH-1:0] eng_a_o,
  output logic [DATA_WIDTH-1:0] eng_b_o,
  input  logic                  eng_done_i,
  input  logic [DATA_WIDTH-1:0] eng_result_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   rr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  rsp_valid_q;
  logic                  start_q;
  logic                  busy_q;

  logic                  gnt_found;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [DATA_WIDTH-1:0] gnt_a;
  logic [DATA_WIDTH-1:0] gnt_b;
  logic [ID_WIDTH:0]     cand;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q;
  logic          err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Rotating priority search: first valid index at or after rr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (ID_WIDTH+1)'(i);
      if (cand >= (ID_WIDTH+1)'(NUM_REQ)) cand = cand - (ID_WIDTH+1)'(NUM_REQ);
      if (!gnt_found && bus.req_valid_i[cand[ID_WIDTH-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  // One-hot grant and operand mux for the winning requester.
  always_comb begin
    gnt_oh = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_idx == ID_WIDTH'(i))) begin
        gnt_oh[i] = 1'b1;
        gnt_a     = bus.req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_b     = bus.req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is only offered in S_IDLE and is forced low while reset is asserted.
  assign bus.req_ready_o = (state_q == S_IDLE && nreset_i) ? gnt_oh : '0;

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = id_q;
  assign bus.rsp_data_o  = res_q;
  assign eng_start_o     = start_q;
  assign eng_a_o         = a_q;
  assign eng_b_o         = b_q;
  assign busy_o          = busy_q;
`ifdef GCD_ARB_TIMEOUT_EN
  assign bus.rsp_err_o   = err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

  // Sequencer: grant, issue, wait for engine, hold response until accepted.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            id_q   <= gnt_idx;
            a_q    <= gnt_a;
            b_q    <= gnt_b;
            busy_q <= 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            if (gnt_a == '0 || gnt_b == '0) begin
              res_q       <= gnt_a | gnt_b;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              start_q <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
`ifdef GCD_ARB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done_i) begin
            res_q       <= eng_result_i;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
`ifdef GCD_ARB_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_q        <= (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed + randomized bench for gcd_arbiter. The engine is modelled here
// (start -> programmable delay -> done with the true gcd); expected grants come
// from a round-robin pointer model and expected results from Euclid's algorithm.
module tb_gcd_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          nreset_i = 1'b0;
  logic          eng_start_o;
  logic [DW-1:0] eng_a_o;
  logic [DW-1:0] eng_b_o;
  logic          eng_done_i;
  logic [DW-1:0] eng_result_i;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  gcd_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  gcd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .bus          (bus),
    .eng_start_o  (eng_start_o),
    .eng_a_o      (eng_a_o),
    .eng_b_o      (eng_b_o),
    .eng_done_i   (eng_done_i),
    .eng_result_i (eng_result_i),
    .busy_o       (busy_o)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  logic [DW-1:0] ra [NR];
  logic [DW-1:0] rb [NR];
  logic [NR-1:0] vm;
  int            ptr;

  always @(negedge clk_i) if (eng_start_o === 1'b1) start_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] gcd_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    if ($urandom_range(0, 3) == 0) return '0;
    return DW'($urandom_range(1, 255));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_reqs();
    bus.req_valid_i = vm;
    for (int k = 0; k < NR; k++) begin
      bus.req_a_i[k*DW +: DW] = ra[k];
      bus.req_b_i[k*DW +: DW] = rb[k];
    end
  endtask

  // Runs one transaction for requester id, assuming the DUT is idle and the
  // request inputs are already driven. Ends just after the response handshake.
  task automatic serve(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int dly, input int stall, input bit drop, input bit spur);
    logic [DW-1:0] exp_d;
    exp_d = gcd_ref(a, b);
    #1;
    check("grant", 32'(bus.req_ready_o), 32'(1 << id));
    tick();
    if (drop) bus.req_valid_i[id] = 1'b0;
    #1;
    check("ready_after_grant", 32'(bus.req_ready_o), 0);
    check("busy", 32'(busy_o), 1);
    if (a == 0 || b == 0) begin
      check("bypass_no_start", 32'(eng_start_o), 0);
      check("bypass_rsp_valid", 32'(bus.rsp_valid_o), 1);
    end else begin
      check("start", 32'(eng_start_o), 1);
      check("eng_a", 32'(eng_a_o), 32'(a));
      check("eng_b", 32'(eng_b_o), 32'(b));
      tick();
      check("start_once", 32'(eng_start_o), 0);
      repeat (dly) tick();
      check("no_rsp_before_done", 32'(bus.rsp_valid_o), 0);
      check("eng_a_stable", 32'(eng_a_o), 32'(a));
      eng_done_i   = 1'b1;
      eng_result_i = exp_d;
      tick();
      eng_done_i   = 1'b0;
      eng_result_i = DW'($urandom);
      check("rsp_valid", 32'(bus.rsp_valid_o), 1);
    end
    check("rsp_id", 32'(bus.rsp_id_o), 32'(id));
    check("rsp_data", 32'(bus.rsp_data_o), 32'(exp_d));
    check("rsp_err", 32'(bus.rsp_err_o), 0);
    for (int s = 0; s < stall; s++) begin
      if (spur) begin
        eng_done_i   = 1'b1;
        eng_result_i = ~exp_d;
      end
      tick();
      eng_done_i = 1'b0;
      check("stall_valid", 32'(bus.rsp_valid_o), 1);
      check("stall_id", 32'(bus.rsp_id_o), 32'(id));
      check("stall_data", 32'(bus.rsp_data_o), 32'(exp_d));
      check("stall_no_ready", 32'(bus.req_ready_o), 0);
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    check("no_grant_in_hs", 32'(bus.req_ready_o), 0);
    tick();
    bus.rsp_ready_i = 1'b0;
    #1;
    check("rsp_valid_clear", 32'(bus.rsp_valid_o), 0);
    check("idle_busy", 32'(busy_o), 0);
  endtask

  initial begin
    int s0;
    int w;
    vm = '0;
    for (int k = 0; k < NR; k++) begin
      ra[k] = '0;
      rb[k] = '0;
    end
    drive_reqs();
    bus.rsp_ready_i = 1'b0;
    eng_done_i      = 1'b0;
    eng_result_i    = '0;

    // Reset state
    tick();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    check("rst_start", 32'(eng_start_o), 0);
    check("rst_ready", 32'(bus.req_ready_o), 0);
    check("rst_data", 32'(bus.rsp_data_o), 0);
    nreset_i = 1'b1;
    tick();

    // Single request, engine answers after 5 cycles
    s0 = start_cnt;
    ra[0] = 8'd12; rb[0] = 8'd18; vm = 4'b0001;
    drive_reqs();
    serve(0, 8'd12, 8'd18, 4, 0, 1'b1, 1'b0);
    vm[0] = 1'b0;
    check("t1_start_count", 32'(start_cnt - s0), 1);

    // Zero-operand bypass on requester 2
    s0 = start_cnt;
    ra[2] = 8'd0; rb[2] = 8'd9; vm = 4'b0100;
    drive_reqs();
    serve(2, 8'd0, 8'd9, 0, 0, 1'b1, 1'b0);
    vm[2] = 1'b0;
    check("t3_no_start", 32'(start_cnt - s0), 0);

    // Long response stall with spurious done and another requester pending
    ra[3] = 8'd35; rb[3] = 8'd21;
    ra[0] = 8'd20; rb[0] = 8'd8;
    vm = 4'b1001;
    drive_reqs();
    serve(3, 8'd35, 8'd21, 2, 10, 1'b1, 1'b1);
    vm[3] = 1'b0;

    // Reset during S_WAIT drops the transaction and restarts priority at 0
    #1;
    check("t5_grant0", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = '0;
    vm = '0;
    #1;
    check("t5_start", 32'(eng_start_o), 1);
    tick();
    tick();
    #2;
    bus.req_valid_i = 4'b0100;
    nreset_i = 1'b0;
    #1;
    check("t5_busy", 32'(busy_o), 0);
    check("t5_start_rst", 32'(eng_start_o), 0);
    check("t5_eng_a", 32'(eng_a_o), 0);
    check("t5_eng_b", 32'(eng_b_o), 0);
    check("t5_rsp_valid", 32'(bus.rsp_valid_o), 0);
    check("t5_ready", 32'(bus.req_ready_o), 0);
    tick();
    nreset_i = 1'b1;
    bus.req_valid_i = '0;
    tick();
    tick();
    check("t5_no_rsp", 32'(bus.rsp_valid_o), 0);

    // All requesters valid continuously: grant order 0,1,2,3,0
    for (int k = 0; k < NR; k++) begin
      ra[k] = 8'(6 * (k + 1));
      rb[k] = 8'(4 * (k + 2));
    end
    vm = 4'b1111;
    drive_reqs();
    for (int n = 0; n < 5; n++)
      serve(n % NR, ra[n % NR], rb[n % NR], n, 1, 1'b0, 1'b0);
    vm = '0;
    drive_reqs();
    ptr = 1;

    // Randomized traffic against the round-robin / gcd model
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NR; k++) begin
        if (!vm[k] && $urandom_range(0, 1) == 1) begin
          vm[k] = 1'b1;
          ra[k] = rnd_op();
          rb[k] = rnd_op();
        end
      end
      if (vm == '0) begin
        vm[it % NR] = 1'b1;
        ra[it % NR] = rnd_op();
        rb[it % NR] = rnd_op();
      end
      drive_reqs();
      w = -1;
      for (int i = 0; i < NR; i++)
        if (w < 0 && vm[(ptr + i) % NR]) w = (ptr + i) % NR;
      serve(w, ra[w], rb[w], $urandom_range(0, 6), $urandom_range(0, 3), 1'b1,
            1'($urandom_range(0, 1)));
      vm[w] = 1'b0;
      ptr = (w + 1) % NR;
    end
    vm = '0;
    drive_reqs();

`ifdef GCD_ARB_TIMEOUT_EN
    // Silent engine: error response TO cycles after S_WAIT entry
    ra[1] = 8'd15; rb[1] = 8'd10; vm = 4'b0010;
    drive_reqs();
    #1;
    check("t6_grant", 32'(bus.req_ready_o), 32'b0010);
    tick();
    bus.req_valid_i = '0;
    check("t6_start", 32'(eng_start_o), 1);
    tick();
    for (int i = 0; i < TO; i++) begin
      check("t6_wait", 32'(bus.rsp_valid_o), 0);
      tick();
    end
    check("t6_rsp_valid", 32'(bus.rsp_valid_o), 1);
    check("t6_err", 32'(bus.rsp_err_o), 1);
    check("t6_data", 32'(bus.rsp_data_o), 0);
    check("t6_id", 32'(bus.rsp_id_o), 1);
    eng_done_i = 1'b1;
    eng_result_i = 8'd5;
    tick();
    eng_done_i = 1'b0;
    check("t6_late_err", 32'(bus.rsp_err_o), 1);
    check("t6_late_data", 32'(bus.rsp_data_o), 0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // Done in the expiry cycle wins
    vm = 4'b0010;
    drive_reqs();
    #1;
    check("t6b_grant", 32'(bus.req_ready_o), 32'b0010);
    tick();
    bus.req_valid_i = '0;
    tick();
    repeat (TO - 1) tick();
    eng_done_i = 1'b1;
    eng_result_i = 8'd5;
    tick();
    eng_done_i = 1'b0;
    check("t6b_rsp_valid", 32'(bus.rsp_valid_o), 1);
    check("t6b_err", 32'(bus.rsp_err_o), 0);
    check("t6b_data", 32'(bus.rsp_data_o), 5);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
